// File: rtl/usr_serial_rx.sv
// Framed serial receiver: start bit, N data bits, optional parity bit, stop bit.
// Received words are presented on a valid/ready interface along with their error flags.
module usr_serial_rx #(
  parameter int N          = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         sin,
  input  logic         bit_en,
  output logic [N-1:0] data,
  output logic         valid,
  input  logic         ready,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  sh_q;
  logic [N-1:0]  sh_d;
  logic          perr_q;
  logic          perr_d;
  logic [N-1:0]  data_q;
  logic          valid_q;
  logic          parity_err_q;
  logic          frame_err_q;
  logic          overrun_q;

  // Parity check over the received word plus its parity bit.
  function automatic logic parity_mismatch(input logic [N-1:0] word, input logic pbit);
    return ((^word) ^ pbit) != PARITY_ODD;
  endfunction

  // Next shift-register value and parity verdict for the current sample.
  always_comb begin
    sh_d   = sh_q;
    perr_d = 1'b0;
    if (MSB_FIRST) begin
      sh_d = {sh_q[N-2:0], sin};
    end else begin
      sh_d = {sin, sh_q[N-1:1]};
    end
    if (PARITY_EN) begin
      perr_d = parity_mismatch(sh_q, sin);
    end else begin
      perr_d = 1'b0;
    end
  end

  // Frame FSM, word delivery and output handshake.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      perr_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (!sin) begin
              state_q <= DATA;
              cnt_q   <= '0;
              perr_q  <= 1'b0;
            end
          end
          DATA: begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= PARITY_EN ? PARITY : STOP;
            end
          end
          PARITY: begin
            perr_q  <= perr_d;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            // A held, unaccepted word wins; the new one is dropped.
            if (!valid_q || ready) begin
              data_q       <= sh_q;
              parity_err_q <= perr_q;
              frame_err_q  <= ~sin;
              valid_q      <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule
